// File: rtl/tick_sched_pkg.sv
// -----------------------------------------------------------------------------
// tick_sched_pkg
// Shared constants and types for the tick scheduler:
//   - DIV_W           : divisor / counter width (covers 100,000,000)
//   - DEF_DIV0..3     : reset divisors for the four standard consumers
//   - CH_VGA..CH_CHAR : channel index constants
//   - cfgState_t      : config FSM state encoding (IDLE / PEND / DONE)
// -----------------------------------------------------------------------------
package tick_sched_pkg;

  localparam int DIV_W = 27;

  // Reset divisors at a 100 MHz system clock
  localparam int DEF_DIV0 = 4;          // VGA pixel, 25 MHz
  localparam int DEF_DIV1 = 200000;     // 7-seg scan, 500 Hz
  localparam int DEF_DIV2 = 100000000;  // game timer, 1 Hz
  localparam int DEF_DIV3 = 10000000;   // character animation, 10 Hz

  localparam int CH_VGA  = 0;
  localparam int CH_SEG  = 1;
  localparam int CH_SEC  = 2;
  localparam int CH_CHAR = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } cfgState_t;

endpackage

// File: rtl/tick_chan.sv
// -----------------------------------------------------------------------------
// tick_chan
// One tick channel: modulo-div counter, divisor register and registered tick.
// tick is high for one cycle every div cycles while run=1; div=0 disables the
// channel. A load replaces the divisor and restarts the period; when it lands
// on the wrap cycle the old period's tick is still emitted.
//
// Optional build macro: TICK_SQUARE_OUT_EN adds output sq, which toggles on
// every tick (half-rate 50% square wave) and is cleared by sync.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   run      in   1 = count, 0 = hold (no ticks)
//   sync     in   clear counter, suppress tick this cycle (beats run)
//   load     in   apply loadDiv and clear the counter
//   loadDiv  in   new divisor (0 = disable)
//   tick     out  registered one-cycle enable
//   wrap     out  this cycle ends a period (tick is set at the next edge)
//   divZero  out  channel currently disabled
//   sq       out  (TICK_SQUARE_OUT_EN only) toggles on every tick
// -----------------------------------------------------------------------------
module tick_chan
  import tick_sched_pkg::*;
#(
  parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV0)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             sync,
  input  logic             load,
  input  logic [DIV_W-1:0] loadDiv,
  output logic             tick,
  output logic             wrap,
  output logic             divZero
`ifdef TICK_SQUARE_OUT_EN
  ,
  output logic             sq
`endif
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;

  assign divZero = (div == '0);
  // Guarding on divZero keeps the div-1 underflow from ever matching.
  assign wrap    = run && !sync && !divZero && (cnt == div - DIV_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      div  <= RST_DIV;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      if (load) begin
        div <= loadDiv;
        cnt <= '0;
      end else if (sync || wrap) begin
        cnt <= '0;
      end else if (run && !divZero) begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

`ifdef TICK_SQUARE_OUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq <= 1'b0;
    end else if (sync) begin
      sq <= 1'b0;
    end else if (wrap) begin
      sq <= ~sq;
    end
  end
`endif

endmodule

// File: rtl/tick_sched.sv
// -----------------------------------------------------------------------------
// tick_sched
// Runtime-programmable timebase: N_CH single-cycle tick enables derived from
// clk. A valid/ready config port reprograms one channel's divisor; the new
// value is held pending and applied only on a period boundary (the channel's
// wrap cycle), or immediately if the channel is disabled, paused or synced,
// so no runt or stretched ticks appear.
//
// Optional build macro: TICK_SQUARE_OUT_EN adds output sq[N_CH].
//
// Ports:
//   clk        in   system clock (100 MHz)
//   rst        in   asynchronous active-low reset
//   run        in   1 = counters advance, 0 = pause
//   sync       in   single-cycle pulse; realigns all channels
//   cfg_valid  in   config request
//   cfg_ready  out  config slot free (IDLE)
//   cfg_ch     in   target channel (>= N_CH accepted, no effect)
//   cfg_div    in   new divisor; 0 disables the channel
//   cfg_done   out  one-cycle pulse after the divisor took effect
//   tick       out  per-channel one-cycle enables
//   sq         out  (TICK_SQUARE_OUT_EN only) per-channel half-rate squares
// -----------------------------------------------------------------------------
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DIV0 = DEF_DIV0,
  parameter int DIV1 = DEF_DIV1,
  parameter int DIV2 = DEF_DIV2,
  parameter int DIV3 = DEF_DIV3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    sync,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]        cfg_div,
  output logic                    cfg_done,
  output logic [N_CH-1:0]         tick
`ifdef TICK_SQUARE_OUT_EN
  ,
  output logic [N_CH-1:0]         sq
`endif
);

  localparam int CH_W = $clog2(N_CH);

  cfgState_t        state;
  cfgState_t        nextState;
  logic [CH_W-1:0]  pendCh;
  logic [DIV_W-1:0] pendDiv;
  logic             applyNow;
  logic             chValid;
  logic [N_CH-1:0]  wrapV;
  logic [N_CH-1:0]  divZeroV;
  logic [N_CH-1:0]  loadV;

  assign chValid   = (32'(pendCh) < N_CH);
  assign cfg_ready = (state == IDLE);
  assign cfg_done  = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pendCh  <= '0;
      pendDiv <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && cfg_valid) begin
        pendCh  <= cfg_ch;
        pendDiv <= cfg_div;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    nextState = state;
    applyNow  = 1'b0;
    unique case (state)
      IDLE: if (cfg_valid) nextState = PEND;
      PEND: begin
        // An out-of-range channel has no boundary to wait for.
        applyNow = !chValid || wrapV[pendCh] || divZeroV[pendCh] || !run || sync;
        if (applyNow) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  for (genvar i = 0; i < N_CH; i++) begin : gCh
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(
      (i == CH_VGA)  ? DIV0 :
      (i == CH_SEG)  ? DIV1 :
      (i == CH_SEC)  ? DIV2 :
      (i == CH_CHAR) ? DIV3 : DIV0);

    assign loadV[i] = applyNow && (pendCh == CH_W'(i));

    tick_chan #(.RST_DIV(RST_DIV)) uChan (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .sync    (sync),
      .load    (loadV[i]),
      .loadDiv (pendDiv),
      .tick    (tick[i]),
      .wrap    (wrapV[i]),
      .divZero (divZeroV[i])
`ifdef TICK_SQUARE_OUT_EN
      ,
      .sq      (sq[i])
`endif
    );
  end

endmodule

// File: tb/tb_tick_sched.sv
// -----------------------------------------------------------------------------
// tb_tick_sched
// Directed bench for tick_sched with shrunk divisors (4 / 10 / 16 / 6).
// Each cycle after reset release is numbered (edge 1 = first posedge) and the
// sampled {cfg_ready, cfg_done, tick[3:0]} is logged; expected tick positions
// are hand-computed windows over that log.
// -----------------------------------------------------------------------------
module tb_tick_sched;
  import tick_sched_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run = 1'b0;
  logic             sync = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             cfg_done;
  logic [3:0]       tick;
`ifdef TICK_SQUARE_OUT_EN
  logic [3:0]       sq;
`endif

  int errCnt = 0;
  int chkCnt = 0;
  int cyc    = 0;
  logic [5:0] rec [0:127];

  always #5 clk = ~clk;

  tick_sched #(
    .N_CH (4),
    .DIV0 (4),
    .DIV1 (10),
    .DIV2 (16),
    .DIV3 (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_done  (cfg_done),
    .tick      (tick)
`ifdef TICK_SQUARE_OUT_EN
    ,
    .sq        (sq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, log the outputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rec[cyc] = {cfg_ready, cfg_done, tick};
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Bit b of the log over cycles from..from+n-1, LSB = cycle from.
  function automatic logic [31:0] win(input int b, input int from, input int n);
    logic [31:0] res;
    res = '0;
    for (int k = 0; k < n; k++) res[k] = rec[from + k][b];
    return res;
  endfunction

  initial begin
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tick",  32'(tick),      32'h0);
    check("rst_ready", 32'(cfg_ready), 32'h1);
    check("rst_done",  32'(cfg_done),  32'h0);

    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    steps(13);                                   // cycle 13: ch0 cnt=1

    // Reprogram VGA to 2 mid-period
    cfg_valid = 1'b1; cfg_ch = 2'(CH_VGA); cfg_div = DIV_W'(2);
    step();                                      // 14: accepted
    cfg_valid = 1'b0;
    steps(6);                                    // 20

    // Back to 4 (applies at wrap 22)
    cfg_valid = 1'b1; cfg_div = DIV_W'(4);
    step();                                      // 21
    cfg_valid = 1'b0;
    steps(3);                                    // 24: ch0 cnt=2

    run = 1'b0;
    steps(7);                                    // 31
    run = 1'b1;
    steps(5);                                    // 36: ch0 wrap cycle next

    sync = 1'b1;
    step();                                      // 37
    sync = 1'b0;
    steps(6);                                    // 43

    // Disable CHAR, then re-enable with 5
    cfg_valid = 1'b1; cfg_ch = 2'(CH_CHAR); cfg_div = '0;
    step();                                      // 44
    cfg_valid = 1'b0;
    steps(6);                                    // 50
    cfg_valid = 1'b1; cfg_div = DIV_W'(5);
    step();                                      // 51
    cfg_valid = 1'b0;
    steps(8);                                    // 59

    check("t1_ch0",        win(0, 1, 12),  32'h888);
    check("t1_ch1",        win(1, 1, 12),  32'h200);
    check("t1_ch2",        win(2, 1, 16),  32'h8000);
    check("t1_ch3",        win(3, 1, 12),  32'h820);
    check("t2_ch0",        win(0, 13, 8),  32'hA8);
    check("t2_done",       win(4, 13, 8),  32'h08);
    check("t2_ready",      win(5, 13, 8),  32'hF1);
    check("t3_ch0_resume", win(0, 25, 10), 32'h100);
    check("t3_pause_any",  win(0, 25, 7) | win(1, 25, 7) | win(2, 25, 7) | win(3, 25, 7), 32'h0);
    check("t4_sync_ch0",   win(0, 37, 9),  32'h110);
    check("t4_sync_ch3",   win(3, 37, 7),  32'h40);
    check("t4_sync_ch1",   win(1, 37, 11), 32'h400);
    check("t5_ch3",        win(3, 44, 16), 32'h2020);
    check("t5_done",       win(4, 44, 16), 32'h120);
    check("t5_ready",      win(5, 44, 16), 32'hFE40);

    // Reset while a request to SEC is pending
    cfg_valid = 1'b1; cfg_ch = 2'(CH_SEC); cfg_div = DIV_W'(3);
    step();                                      // 60
    cfg_valid = 1'b0;
    steps(2);                                    // 62
    check("t6_pend_ready", 32'(cfg_ready), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_tick",  32'(tick),      32'h0);
    check("t6_async_ready", 32'(cfg_ready), 32'h1);
    check("t6_async_done",  32'(cfg_done),  32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    steps(16);
    check("t6_ch2_default", win(2, 1, 16), 32'h8000);
    check("t6_ch0_default", win(0, 1, 16), 32'h8888);
    check("t6_no_done",     win(4, 1, 16), 32'h0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
- Runtime-programmable timebase controller. Replaces free-running derived clocks with single-cycle tick enables, one per consumer channel (VGA pixel, 7-seg scan, 1 Hz game timer, character animation).
- Sits beside the system clock. All downstream logic runs on clk, qualified by tick[i].
- Game FSM reprograms channel rates through a valid/ready config port, applied glitch-free on period boundaries, and can pause/realign all channels.

Parameters:
- N_CH, 4, number of tick channels.
- DIV_W, 27, divisor width; covers 100,000,000.
- DIV0, 4, reset divisor for channel 0 (VGA, 25 MHz at 100 MHz clk).
- DIV1, 200000, reset divisor for channel 1 (7-seg, 500 Hz).
- DIV2, 100000000, reset divisor for channel 2 (1 Hz).
- DIV3, 10000000, reset divisor for channel 3 (char, 10 Hz).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous active-low reset.
- run  input  1  1 = counters advance; 0 = pause.
- sync  input  1  single-cycle pulse; realigns all channels.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config slot free.
- cfg_ch  input  $clog2(N_CH)  target channel.
- cfg_div  input  DIV_W  new divisor; 0 = disable channel.
- cfg_done  output  1  one-cycle pulse when the pending divisor takes effect.
- tick  output  N_CH  per-channel one-cycle enables.

Behaviour:
- Reset (rst low, async): cnt[i]=0, div[i]=DIVi, tick=0, cfg_ready=1, cfg_done=0, config FSM=IDLE.
- Channel i, div D≥1, run=1: cnt increments each cycle, wrapping D-1→0.
  - tick[i] is registered and high for exactly 1 cycle per D cycles.
  - First tick occurs on the D-th clk edge after reset release.
  - D=1 gives tick[i] held high continuously.
- D=0: channel disabled. cnt held at 0; tick[i]=0.
- run=0: all cnt hold and tick=0. Ticks resume with the remaining count when run returns to 1.
- sync=1: all cnt←0 and tick=0 in that cycle. The next tick on each channel comes D cycles later. sync has priority over run.
- Divisor arithmetic: unsigned DIV_W. cfg_div wider than the counter is impossible by construction. No saturation is needed.
- Config FSM states:
  - IDLE (cfg_ready=1): on cfg_valid, latch ch/div and go to PEND.
  - PEND (cfg_ready=0): apply the latched div to div[ch] and clear cnt[ch] on the first of these events: the channel's wrap cycle (the cycle it emits tick), current div[ch]=0, run=0, or sync=1. Then go to DONE.
  - DONE: cfg_done=1 for 1 cycle, then IDLE.
- Timing of an applied divisor: at a wrap, the tick of the old period is still emitted, and the new period starts the following cycle. No runt or stretched ticks on any channel.
- Config accept latency ≥3 cycles. cfg_ready is low in PEND and DONE. cfg_valid outside IDLE is ignored (not queued).
- cfg_ch ≥ N_CH is accepted but has no effect on any channel; cfg_done still pulses.
- Reset mid-PEND: the request is dropped, no cfg_done, and divisors return to their defaults.
- Simultaneous events:
  - Wrap and sync in the same cycle: sync wins, so no tick.
  - Config apply on the wrap cycle: the tick is still emitted that cycle.

Optional Feature:
- TICK_SQUARE_OUT_EN defined: adds output sq[N_CH]. Each bit toggles on every tick[i], giving a 50% duty square wave at half the tick rate, for legacy clock-style consumers. sq resets to 0; sync clears it to 0.
- Undefined: the sq port and its registers are absent.

Decomposition:
- Package tick_sched_pkg holds:
  - channel index constants CH_VGA=0, CH_SEG=1, CH_SEC=2, CH_CHAR=3;
  - DIV_W and the default divisor constants;
  - config FSM state enum IDLE/PEND/DONE.
- Sub-module tick_chan (instantiated N_CH times), containing:
  - counter, divisor register and registered tick;
  - inputs load/load_div, run, sync;
  - output wrap.
- The top level holds the config FSM and the apply logic.

Test Plan:
- Reset release with run=1, DIV0=4 → tick[0] high on cycles 4, 8, 12 and low otherwise; tick[1] first at cycle 200000 (shrink parameters to DIV1=10 for sim).
- Reprogram CH_VGA to div 2 mid-period at cnt=1 → the old tick still arrives at cycle 4. Ticks then follow at 6 and 8; cfg_done pulses once; cfg_ready stays low until the done cycle ends.
- run=0 for 7 cycles with cnt[0]=2 → no ticks during the pause. The next tick arrives 2 cycles after run returns to 1.
- sync pulse on a wrap cycle, DIV0=4 → no tick that cycle; the next tick is exactly 4 cycles later; all channels are realigned.
- cfg_div=0 on ch 3, then cfg_div=5 → tick[3] stays low. The re-enable applies in the next cycle, and the first tick comes 5 cycles after apply.
- Assert rst low while in PEND → outputs return to reset values immediately (async), no cfg_done, and div[ch] returns to its default.
